// File: rtl/bus_b_sequencer_if.sv
// Handshake and source-enable bundle between the instruction decoder, the
// B-bus sequencer and the B-bus source block.
interface bus_b_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_kind;
    logic [3:0]  op_reg;
    logic [15:0] op_rlist;
    logic        data_valid;
    logic        abort;
    logic        rb_en;
    logic [3:0]  rb_addr;
    logic        pc_en;
    logic [4:0]  instr_in_en;
    logic        instr_src;
    logic        bus_valid;
    logic        done;
    logic        timeout;
    logic        busy;

    modport master (
        output op_valid, op_kind, op_reg, op_rlist, data_valid, abort,
        input  op_ready, rb_en, rb_addr, pc_en, instr_in_en, instr_src,
               bus_valid, done, timeout, busy
    );

    modport slave (
        input  op_valid, op_kind, op_reg, op_rlist, data_valid, abort,
        output op_ready, rb_en, rb_addr, pc_en, instr_in_en, instr_src,
               bus_valid, done, timeout, busy
    );
endinterface

// File: rtl/bus_b_sequencer.sv
// B-bus source sequencer: one operation at a time, driving register bank, PC
// or byte-lane enables per cycle, including register lists and load-data waits.
module bus_b_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic             phi2_clk,
    input  logic             nreset,
    bus_b_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_LIST  = 2'd3;

    localparam logic [2:0] K_REG   = 3'd0;
    localparam logic [2:0] K_PC    = 3'd1;
    localparam logic [2:0] K_IMM8  = 3'd2;
    localparam logic [2:0] K_IMM12 = 3'd3;
    localparam logic [2:0] K_IMM24 = 3'd4;
    localparam logic [2:0] K_DIN   = 3'd5;
    localparam logic [2:0] K_RLIST = 3'd6;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    logic [1:0]  state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rb_en_q, rb_en_d;
    logic [3:0]  rb_addr_q, rb_addr_d;
    logic        pc_en_q, pc_en_d;
    logic [4:0]  lanes_q, lanes_d;
    logic        src_q, src_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic        ready_s;
    logic        accept_s;
    logic [15:0] list_src_s;
    logic [3:0]  list_idx_s;
    logic [15:0] list_rem_s;
    logic        list_rb_s;
    logic        list_pc_s;

    function automatic logic [3:0] lowest_bit(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign ready_s  = !bus.abort && ((state_q == ST_IDLE) ||
                      (done_q && ((state_q == ST_DRIVE) || (state_q == ST_LIST))));
    assign accept_s = bus.op_valid && ready_s;

    // The list being stepped is the freshly offered one on acceptance, else the latched remainder.
    assign list_src_s = accept_s ? bus.op_rlist : list_q;
    assign list_idx_s = lowest_bit(list_src_s);
    assign list_rem_s = list_src_s & ~(16'd1 << list_idx_s);
    assign list_pc_s  = (list_src_s != 16'd0) && (list_idx_s == 4'd15);
    assign list_rb_s  = (list_src_s != 16'd0) && (list_idx_s != 4'd15);

    // Next state and next-cycle source enables.
    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        cnt_d     = cnt_q;
        rb_en_d   = 1'b0;
        rb_addr_d = 4'd0;
        pc_en_d   = 1'b0;
        lanes_d   = 5'b00000;
        src_d     = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            list_d  = 16'd0;
            cnt_d   = 8'd0;
        end else if (accept_s) begin
            state_d = ST_DRIVE;
            list_d  = 16'd0;
            cnt_d   = 8'd0;
            done_d  = 1'b1;
            case (bus.op_kind)
                K_REG: begin
                    if (bus.op_reg == 4'd15) begin
                        pc_en_d = 1'b1;
                    end else begin
                        rb_en_d   = 1'b1;
                        rb_addr_d = bus.op_reg;
                    end
                end
                K_PC:    pc_en_d = 1'b1;
                K_IMM8:  lanes_d = 5'b00001;
                K_IMM12: lanes_d = 5'b00111;
                K_IMM24: lanes_d = 5'b01111;
                K_DIN: begin
                    state_d = ST_WAIT;
                    done_d  = 1'b0;
                end
                K_RLIST: begin
                    state_d   = ST_LIST;
                    rb_en_d   = list_rb_s;
                    rb_addr_d = list_rb_s ? list_idx_s : 4'd0;
                    pc_en_d   = list_pc_s;
                    list_d    = list_rem_s;
                    done_d    = (list_rem_s == 16'd0);
                end
                default: done_d = 1'b1;
            endcase
        end else begin
            case (state_q)
                ST_DRIVE: state_d = ST_IDLE;
                ST_LIST: begin
                    if (done_q) begin
                        state_d = ST_IDLE;
                        list_d  = 16'd0;
                    end else begin
                        rb_en_d   = list_rb_s;
                        rb_addr_d = list_rb_s ? list_idx_s : 4'd0;
                        pc_en_d   = list_pc_s;
                        list_d    = list_rem_s;
                        done_d    = (list_rem_s == 16'd0);
                    end
                end
                ST_WAIT: begin
                    // Data arriving on the expiry edge wins over the timeout.
                    if (bus.data_valid) begin
                        state_d = ST_DRIVE;
                        cnt_d   = 8'd0;
                        lanes_d = 5'b11111;
                        src_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if ((cnt_q + 8'd1) == WAIT_LIMIT) begin
                        state_d   = ST_IDLE;
                        cnt_d     = 8'd0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        valid_d = rb_en_d | pc_en_d | (|lanes_d);
    end

    // State and registered outputs.
    always_ff @(posedge phi2_clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            list_q    <= 16'd0;
            cnt_q     <= 8'd0;
            rb_en_q   <= 1'b0;
            rb_addr_q <= 4'd0;
            pc_en_q   <= 1'b0;
            lanes_q   <= 5'b00000;
            src_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            cnt_q     <= cnt_d;
            rb_en_q   <= rb_en_d;
            rb_addr_q <= rb_addr_d;
            pc_en_q   <= pc_en_d;
            lanes_q   <= lanes_d;
            src_q     <= src_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.op_ready    = ready_s;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rb_en       = rb_en_q;
    assign bus.rb_addr     = rb_addr_q;
    assign bus.pc_en       = pc_en_q;
    assign bus.instr_in_en = lanes_q;
    assign bus.instr_src   = src_q;
    assign bus.bus_valid   = valid_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_b_sequencer.sv
// Bench for bus_b_sequencer: directed steps then random traffic, checked each
// cycle against an operation-level reference model (queue of expected cycles).
module tb_bus_b_sequencer;
    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic       rb_en;
        logic [3:0] rb_addr;
        logic       pc_en;
        logic [4:0] lanes;
        logic       src;
        logic       done;
        logic       timeout;
    } rec_t;

    logic phi2_clk;
    logic nreset;
    bus_b_sequencer_if bus();

    bus_b_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .phi2_clk (phi2_clk),
        .nreset   (nreset),
        .bus      (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t m_cur;
    rec_t m_pend[$];
    bit   m_wait;
    bit   m_active;
    int   m_wcnt;

    initial begin
        phi2_clk = 1'b0;
        forever #5 phi2_clk = ~phi2_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = '0;
        m_pend.delete();
        m_wait = 1'b0;
        m_active = 1'b0;
        m_wcnt = 0;
    endtask

    // Expected behaviour of one rising edge, from the operation rules.
    task automatic model_edge(input bit rdy, output bit acc);
        rec_t r;
        acc = 1'b0;
        if (bus.abort) begin
            model_reset();
        end else if (bus.op_valid && rdy) begin
            acc = 1'b1;
            m_pend.delete();
            m_wait = 1'b0;
            m_active = 1'b1;
            m_cur = '0;
            m_cur.done = 1'b1;
            case (bus.op_kind)
                3'd0: if (bus.op_reg == 4'd15) m_cur.pc_en = 1'b1;
                      else begin m_cur.rb_en = 1'b1; m_cur.rb_addr = bus.op_reg; end
                3'd1: m_cur.pc_en = 1'b1;
                3'd2: m_cur.lanes = 5'b00001;
                3'd3: m_cur.lanes = 5'b00111;
                3'd4: m_cur.lanes = 5'b01111;
                3'd5: begin
                    m_cur = '0;
                    m_active = 1'b0;
                    m_wait = 1'b1;
                    m_wcnt = 0;
                end
                3'd6: begin
                    for (int n = 0; n < 16; n++) begin
                        if (bus.op_rlist[n]) begin
                            r = '0;
                            if (n == 15) r.pc_en = 1'b1;
                            else begin r.rb_en = 1'b1; r.rb_addr = 4'(n); end
                            m_pend.push_back(r);
                        end
                    end
                    if (m_pend.size() == 0) m_pend.push_back(rec_t'(0));
                    m_pend[m_pend.size() - 1].done = 1'b1;
                    m_cur = m_pend.pop_front();
                end
                default: ;
            endcase
        end else if (m_wait) begin
            m_cur = '0;
            if (bus.data_valid) begin
                m_cur.lanes = 5'b11111;
                m_cur.src = 1'b1;
                m_cur.done = 1'b1;
                m_wait = 1'b0;
                m_active = 1'b1;
            end else begin
                m_wcnt++;
                if (m_wcnt == WAIT_MAX) begin
                    m_cur.timeout = 1'b1;
                    m_wait = 1'b0;
                end
            end
        end else if (m_active && m_pend.size() > 0) begin
            m_cur = m_pend.pop_front();
        end else begin
            m_cur = '0;
            m_active = 1'b0;
        end
    endtask

    task automatic chk_out(input string tag);
        logic [14:0] o;
        logic [14:0] e;
        logic        bv;
        bv = m_cur.rb_en | m_cur.pc_en | (|m_cur.lanes);
        o = {bus.rb_en, (m_cur.rb_en ? bus.rb_addr : 4'd0), bus.pc_en, bus.instr_in_en,
             bus.instr_src, bus.bus_valid, bus.done, bus.timeout};
        e = {m_cur.rb_en, m_cur.rb_addr, m_cur.pc_en, m_cur.lanes,
             m_cur.src, bv, m_cur.done, m_cur.timeout};
        chk(tag, 32'(o), 32'(e));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/out"}, 32'({bus.rb_en, bus.rb_addr, bus.pc_en, bus.instr_in_en, bus.instr_src,
                                bus.bus_valid, bus.done, bus.timeout}), 32'd0);
        chk({tag, "/op_ready"}, 32'(bus.op_ready), 32'd1);
        chk({tag, "/busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic step(input string tag, output bit acc);
        bit rdy;
        #1;
        rdy = !bus.abort && (!(m_wait || m_active) || m_cur.done);
        chk({tag, "/op_ready"}, 32'(bus.op_ready), 32'(rdy));
        chk({tag, "/busy"}, 32'(bus.busy), 32'(m_wait || m_active));
        @(posedge phi2_clk);
        model_edge(rdy, acc);
        #1;
        chk_out({tag, "/out"});
    endtask

    task automatic issue(input string tag, input logic [2:0] k, input logic [3:0] r,
                         input logic [15:0] l);
        bit acc;
        acc = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_kind  = k;
        bus.op_reg   = r;
        bus.op_rlist = l;
        for (int i = 0; i < 40 && !acc; i++) step(tag, acc);
        bus.op_valid = 1'b0;
        chk({tag, "/accepted"}, 32'(acc), 32'd1);
    endtask

    task automatic idle(input string tag, input int n);
        bit acc;
        bus.op_valid = 1'b0;
        for (int i = 0; i < n; i++) step(tag, acc);
    endtask

    initial begin
        bit acc;
        nreset = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_kind = 3'd0;
        bus.op_reg = 4'd3;
        bus.op_rlist = 16'd0;
        bus.data_valid = 1'b0;
        bus.abort = 1'b0;
        model_reset();
        #2;
        chk_reset("reset");
        @(posedge phi2_clk);
        @(posedge phi2_clk);
        #1;
        chk_reset("reset_hold");
        nreset = 1'b1;
        bus.op_valid = 1'b0;

        issue("reg3", 3'd0, 4'd3, 16'd0);
        issue("reg15", 3'd0, 4'd15, 16'd0);
        idle("reg_idle", 2);

        issue("imm8", 3'd2, 4'd0, 16'd0);
        issue("imm12", 3'd3, 4'd0, 16'd0);
        issue("imm24", 3'd4, 4'd0, 16'd0);
        idle("imm_idle", 2);

        issue("rlist8005", 3'd6, 4'd0, 16'h8005);
        idle("rlist8005", 3);
        issue("rlist0", 3'd6, 4'd0, 16'h0000);
        idle("rlist0", 2);
        issue("rsvd", 3'd7, 4'd0, 16'd0);
        idle("rsvd", 2);

        issue("din4", 3'd5, 4'd0, 16'd0);
        idle("din4_wait", 3);
        bus.data_valid = 1'b1;
        idle("din4_take", 1);
        bus.data_valid = 1'b0;
        idle("din4_end", 2);

        issue("din_to", 3'd5, 4'd0, 16'd0);
        idle("din_to", WAIT_MAX + 2);

        issue("din_exp", 3'd5, 4'd0, 16'd0);
        idle("din_exp_wait", WAIT_MAX - 1);
        bus.data_valid = 1'b1;
        idle("din_exp_take", 1);
        bus.data_valid = 1'b0;
        idle("din_exp_end", 2);

        issue("abort_list", 3'd6, 4'd0, 16'h00FF);
        idle("abort_list", 1);
        bus.abort = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_kind = 3'd0;
        bus.op_reg = 4'd5;
        step("abort", acc);
        bus.abort = 1'b0;
        bus.op_valid = 1'b0;
        idle("abort_after", 3);

        issue("areset_din", 3'd5, 4'd0, 16'd0);
        idle("areset_din", 2);
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        chk_reset("areset_din");
        #10;
        chk_reset("areset_din_hold");
        nreset = 1'b1;

        issue("areset_list", 3'd6, 4'd0, 16'hFFFF);
        idle("areset_list", 1);
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        chk_reset("areset_list");
        #10;
        nreset = 1'b1;
        issue("post_reset", 3'd0, 4'd7, 16'd0);
        idle("post_reset", 1);

        for (int c = 0; c < 400; c++) begin
            bus.op_valid   = ($urandom_range(0, 2) != 0);
            bus.op_kind    = 3'($urandom_range(0, 7));
            bus.op_reg     = 4'($urandom_range(0, 15));
            bus.op_rlist   = ($urandom_range(0, 3) == 0) ? 16'd0 : (16'($urandom) & 16'($urandom));
            bus.data_valid = ($urandom_range(0, 3) == 0);
            bus.abort      = ($urandom_range(0, 19) == 0);
            step("rand", acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
